// File: rtl/cia_serial_port_pkg.sv
// rtl/cia_serial_port_pkg.sv - shared CIA serial port types and constants
package cia_serial_port_pkg;

  // Output-mode shifter states
  typedef enum logic {
    SP_IDLE  = 1'b0,
    SP_SHIFT = 1'b1
  } sp_state_t;

  localparam int BITCNT_W = 3;

  // SDR sits at this offset in the CIA register map
  localparam logic [3:0] SDR_OFFSET = 4'hC;

  // Append one serial bit at the LSB end (MSB-first reception)
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic bit_in);
    return {cur[6:0], bit_in};
  endfunction

endpackage

// File: rtl/cia_serial_port_if.sv
// rtl/cia_serial_port_if.sv - CPU bus view of the serial data register
interface cia_serial_port_if;
  logic       wr;
  logic       sdr;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output wr, output sdr, output data_in, input data_out);
  modport slave  (input wr, input sdr, input data_in, output data_out);
endinterface

// File: rtl/cia_serial_port_sync_edge.sv
// rtl/cia_serial_port_sync_edge.sv - CNT synchroniser with rising-edge detect
module cia_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clk7_en,
  input  logic d,
  input  logic prime,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain and previous-value flop; lines idle high so reset to 1
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (!reset_n) begin
        sync_q <= '1;
        prev_q <= 1'b1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        prev_q <= q;
      end
    end
  end

  assign q = sync_q[SYNC_STAGES-1];
  // A rise seen in the period of a mode change is discarded, so a new mode starts clean
  assign rise = q & ~prev_q & ~prime;

endmodule

// File: rtl/cia_serial_port.sv
// rtl/cia_serial_port.sv - CIA 8520 serial data register and shift logic
module cia_serial_port
  import cia_serial_port_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int BITS        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clk7_en,
  cia_serial_port_if.slave    bus,
  input  logic                spmode,
  input  logic                tmra_ovf,
  input  logic                sp_in,
  input  logic                cnt_in,
  output logic                sp_out,
  output logic                cnt_out,
  output logic                sp_oe,
  output logic                irq
);

  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(BITS - 1);

  sp_state_t             state_q, state_d;
  logic [7:0]            sdr_q, sdr_d;
  logic [7:0]            shreg_q, shreg_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic                  pending_q, pending_d;
  logic                  sp_out_q, sp_out_d;
  logic                  cnt_out_q, cnt_out_d;
  logic                  irq_q, irq_d;
  logic                  spmode_q;
  logic [SYNC_STAGES-1:0] sp_sync_q;

  logic       sp_sync;
  logic       cnt_sync;
  logic       cnt_rise;
  logic       mode_chg;
  logic       wr_sdr;
  logic [7:0] reload;
  logic [7:0] rx_byte;

  assign mode_chg = spmode ^ spmode_q;
  assign wr_sdr   = bus.wr & bus.sdr;
  assign sp_sync  = sp_sync_q[SYNC_STAGES-1];

  cia_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cnt_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .clk7_en (clk7_en),
    .d       (cnt_in),
    .prime   (mode_chg),
    .q       (cnt_sync),
    .rise    (cnt_rise)
  );

  // SP data line only needs synchronising; it is sampled on CNT rises
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (!reset_n) sp_sync_q <= '1;
      else          sp_sync_q <= {sp_sync_q[SYNC_STAGES-2:0], sp_in};
    end
  end

  // Next-state for the SDR, shifter, bit counter and output FSM
  always_comb begin
    state_d   = state_q;
    sdr_d     = sdr_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    pending_d = pending_q;
    sp_out_d  = sp_out_q;
    cnt_out_d = cnt_out_q;
    irq_d     = 1'b0;
    reload    = wr_sdr ? bus.data_in : sdr_q;
    rx_byte   = shift_in(shreg_q, sp_sync);

    if (mode_chg) begin
      if (wr_sdr) sdr_d = bus.data_in;
      state_d   = SP_IDLE;
      bitcnt_d  = '0;
      cnt_out_d = 1'b1;
      pending_d = 1'b0;
      if (!spmode) sp_out_d = 1'b1;
    end else if (spmode) begin
      if (wr_sdr) begin
        sdr_d     = bus.data_in;
        pending_d = 1'b1;
      end
      case (state_q)
        SP_IDLE: begin
          if (pending_d) begin
            shreg_d   = reload;
            pending_d = 1'b0;
            bitcnt_d  = '0;
            cnt_out_d = 1'b1;
            state_d   = SP_SHIFT;
          end
        end
        SP_SHIFT: begin
          if (tmra_ovf) begin
            if (cnt_out_q) begin
              // Falling CNT: present the next bit, MSB first
              cnt_out_d = 1'b0;
              sp_out_d  = shreg_q[7];
              shreg_d   = {shreg_q[6:0], 1'b0};
            end else begin
              // Rising CNT: the receiver samples here
              cnt_out_d = 1'b1;
              if (bitcnt_q == LAST_BIT) begin
                irq_d    = 1'b1;
                bitcnt_d = '0;
                if (pending_d) begin
                  shreg_d   = reload;
                  pending_d = 1'b0;
                end else begin
                  state_d = SP_IDLE;
                end
              end else begin
                bitcnt_d = bitcnt_q + BITCNT_W'(1);
              end
            end
          end
        end
        default: state_d = SP_IDLE;
      endcase
    end else begin
      if (wr_sdr) begin
        sdr_d     = bus.data_in;
        pending_d = 1'b0;
      end
      state_d   = SP_IDLE;
      cnt_out_d = 1'b1;
      sp_out_d  = 1'b1;
      if (cnt_rise) begin
        shreg_d = rx_byte;
        if (bitcnt_q == LAST_BIT) begin
          // A received byte overrides a bus write in the same period
          sdr_d    = rx_byte;
          irq_d    = 1'b1;
          bitcnt_d = '0;
        end else begin
          bitcnt_d = bitcnt_q + BITCNT_W'(1);
        end
      end
    end
  end

  // State register; nothing moves unless clk7_en is high
  always_ff @(posedge clk) begin
    if (clk7_en) begin
      spmode_q <= spmode;
      if (!reset_n) begin
        state_q   <= SP_IDLE;
        sdr_q     <= '0;
        shreg_q   <= '0;
        bitcnt_q  <= '0;
        pending_q <= 1'b0;
        sp_out_q  <= 1'b1;
        cnt_out_q <= 1'b1;
        irq_q     <= 1'b0;
      end else begin
        state_q   <= state_d;
        sdr_q     <= sdr_d;
        shreg_q   <= shreg_d;
        bitcnt_q  <= bitcnt_d;
        pending_q <= pending_d;
        sp_out_q  <= sp_out_d;
        cnt_out_q <= cnt_out_d;
        irq_q     <= irq_d;
      end
    end
  end

  assign bus.data_out = (~bus.wr & bus.sdr) ? sdr_q : 8'h00;
  assign sp_out       = sp_out_q;
  assign cnt_out      = cnt_out_q;
  assign sp_oe        = spmode;
  assign irq          = irq_q;

endmodule

// File: tb/tb_cia_serial_port.sv
// tb/tb_cia_serial_port.sv - directed self-checking bench for cia_serial_port
module tb_cia_serial_port;
  import cia_serial_port_pkg::*;

  logic clk = 1'b0;
  logic reset_n, clk7_en, spmode, tmra_ovf, sp_in, cnt_in;
  logic sp_out, cnt_out, sp_oe, irq;
  int   n_cmp = 0;
  int   n_err = 0;
  int   irq_seen = 0;
  int   irq_base;

  cia_serial_port_if bus();

  cia_serial_port #(.SYNC_STAGES(2), .BITS(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk7_en  (clk7_en),
    .bus      (bus),
    .spmode   (spmode),
    .tmra_ovf (tmra_ovf),
    .sp_in    (sp_in),
    .cnt_in   (cnt_in),
    .sp_out   (sp_out),
    .cnt_out  (cnt_out),
    .sp_oe    (sp_oe),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (irq === 1'b1) irq_seen++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_sdr(input logic [7:0] v);
    bus.wr = 1'b1; bus.sdr = 1'b1; bus.data_in = v;
    step();
    bus.wr = 1'b0; bus.sdr = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] exp);
    bus.wr = 1'b0; bus.sdr = 1'b1;
    #1;
    chk(tag, bus.data_out, exp);
    bus.sdr = 1'b0;
  endtask

  task automatic pulse(input string tag, input logic e_cnt, input logic e_sp, input logic e_irq);
    tmra_ovf = 1'b1;
    step();
    tmra_ovf = 1'b0;
    chk({tag, ".cnt"}, {7'd0, cnt_out}, {7'd0, e_cnt});
    chk({tag, ".sp"},  {7'd0, sp_out},  {7'd0, e_sp});
    chk({tag, ".irq"}, {7'd0, irq},     {7'd0, e_irq});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      step();
      chk("idle.irq", {7'd0, irq}, 8'd0);
    end
  endtask

  // Bits first..last of b (0 = MSB); each is a CNT fall then a rise 4 periods apart
  task automatic send_bits(input string tag, input logic [7:0] b, input int first,
                           input int last, input int gap);
    for (int i = first; i <= last; i++) begin
      pulse({tag, ".fall"}, 1'b0, b[7-i], 1'b0);
      idle(3);
      pulse({tag, ".rise"}, 1'b1, b[7-i], i == 7);
      idle((i == last) ? gap : 3);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      sp_in = b[7-i];
      cnt_in = 1'b0;
      repeat (4) step();
      cnt_in = 1'b1;
      repeat (4) step();
    end
  endtask

  initial begin
    $display("sdr register offset 0x%h", SDR_OFFSET);
    reset_n = 1'b0; clk7_en = 1'b1; spmode = 1'b1; tmra_ovf = 1'b0;
    sp_in = 1'b1; cnt_in = 1'b1;
    bus.wr = 1'b0; bus.sdr = 1'b0; bus.data_in = 8'h00;
    repeat (3) step();
    chk("rst.sp_out",  {7'd0, sp_out},  8'd1);
    chk("rst.cnt_out", {7'd0, cnt_out}, 8'd1);
    chk("rst.irq",     {7'd0, irq},     8'd0);
    chk("rst.sp_oe",   {7'd0, sp_oe},   8'd1);
    chk("rst.noread",  bus.data_out,    8'h00);
    read_chk("rst.sdr", 8'h00);
    reset_n = 1'b1;
    step();

    // 1: transmit 0xA5
    write_sdr(8'hA5);
    read_chk("t1.sdr", 8'hA5);
    send_bits("t1", 8'hA5, 0, 7, 3);
    chk("t1.idle_cnt", {7'd0, cnt_out}, 8'd1);
    chk("t1.idle_sp",  {7'd0, sp_out},  8'd1);

    // 2: 0x3C with 0xFF written mid-byte, back-to-back
    write_sdr(8'h3C);
    send_bits("t2a", 8'h3C, 0, 5, 3);
    write_sdr(8'hFF);
    chk("t2.wr_irq", {7'd0, irq}, 8'd0);
    send_bits("t2a", 8'h3C, 6, 7, 0);
    send_bits("t2b", 8'hFF, 0, 7, 3);
    chk("t2.hold_sp", {7'd0, sp_out}, 8'd1);

    // 3: receive 0x5A
    spmode = 1'b0;
    step();
    chk("t3.sp_oe",   {7'd0, sp_oe},   8'd0);
    chk("t3.cnt_out", {7'd0, cnt_out}, 8'd1);
    chk("t3.sp_out",  {7'd0, sp_out},  8'd1);
    irq_base = irq_seen;
    rx_byte(8'h5A);
    idle(2);
    chk("t3.irqs", 8'(irq_seen - irq_base), 8'd1);
    read_chk("t3.sdr", 8'h5A);
    chk("t3.cnt_out2", {7'd0, cnt_out}, 8'd1);

    // 4: abort output after 5 bits, then receive 0x81
    spmode = 1'b1;
    step();
    write_sdr(8'hC3);
    send_bits("t4", 8'hC3, 0, 4, 3);
    pulse("t4.fall6", 1'b0, 1'b0, 1'b0);
    irq_base = irq_seen;
    spmode = 1'b0;
    step();
    chk("t4.cnt_out", {7'd0, cnt_out}, 8'd1);
    chk("t4.sp_out",  {7'd0, sp_out},  8'd1);
    chk("t4.irq",     {7'd0, irq},     8'd0);
    idle(4);
    chk("t4.noirq", 8'(irq_seen - irq_base), 8'd0);
    read_chk("t4.sdr_kept", 8'hC3);
    rx_byte(8'h81);
    idle(2);
    chk("t4.irqs", 8'(irq_seen - irq_base), 8'd1);
    read_chk("t4.sdr", 8'h81);

    // 5: reset during bit 3, then transmit 0x01
    spmode = 1'b1;
    step();
    write_sdr(8'h5A);
    send_bits("t5a", 8'h5A, 0, 1, 3);
    pulse("t5.fall3", 1'b0, 1'b0, 1'b0);
    irq_base = irq_seen;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("t5.cnt_out", {7'd0, cnt_out}, 8'd1);
    chk("t5.sp_out",  {7'd0, sp_out},  8'd1);
    chk("t5.irq",     {7'd0, irq},     8'd0);
    read_chk("t5.sdr", 8'h00);
    pulse("t5.dead", 1'b1, 1'b1, 1'b0);
    idle(4);
    chk("t5.noirq", 8'(irq_seen - irq_base), 8'd0);
    write_sdr(8'h01);
    send_bits("t5b", 8'h01, 0, 7, 3);

    // 6: clock enable low freezes everything
    clk7_en = 1'b0;
    bus.wr = 1'b1; bus.sdr = 1'b1; bus.data_in = 8'h77;
    #1;
    chk("t6.wr_read", bus.data_out, 8'h00);
    tmra_ovf = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cnt_in = k[0];
      step();
    end
    tmra_ovf = 1'b0; cnt_in = 1'b1;
    bus.wr = 1'b0; bus.sdr = 1'b0;
    chk("t6.cnt_out", {7'd0, cnt_out}, 8'd1);
    chk("t6.sp_out",  {7'd0, sp_out},  8'd1);
    chk("t6.irq",     {7'd0, irq},     8'd0);
    read_chk("t6.sdr", 8'h01);
    clk7_en = 1'b1;
    step();
    pulse("t6.idle", 1'b1, 1'b1, 1'b0);
    read_chk("t6.sdr2", 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
